// File: rtl/hamming_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hamming_pkg                                                   |
// | Purpose  : Shared types, bit-position constants and the data-extraction  |
// |            helper for the extended Hamming(8,4) receive path.            |
// | Contents : estado_t           word classification                       |
// |            POS_W0..POS_W3     positions of the data bits in the word     |
// |            POS_P0             position of the overall parity bit         |
// |            extraer_dato()     pulls {w3,w2,w1,w0} out of a codeword      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package hamming_pkg;

  typedef enum logic [1:0] {
    SIN_ERROR = 2'd0,
    CORREGIDO = 2'd1,
    DOBLE     = 2'd2
  } estado_t;

  localparam int POS_P0 = 0;
  localparam int POS_W0 = 3;
  localparam int POS_W1 = 5;
  localparam int POS_W2 = 6;
  localparam int POS_W3 = 7;

  function automatic logic [3:0] extraer_dato(input logic [7:0] palabra);
    return {palabra[POS_W3], palabra[POS_W2], palabra[POS_W1], palabra[POS_W0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/contador_sat.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : contador_sat                                                  |
// | Purpose  : Saturating up-counter with synchronous clear.                 |
// | Ports    : clk  in   clock, rising edge                                  |
// |            rst  in   synchronous active-high reset                       |
// |            clr  in   synchronous clear, dominates inc                    |
// |            inc  in   count one event                                     |
// |            q    out  W-bit count, sticks at all-ones                     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module contador_sat #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule
`default_nettype wire

// File: rtl/corrector_hamming.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : corrector_hamming                                             |
// | Purpose  : Correction / data-extraction stage of the extended            |
// |            Hamming(8,4) receiver. Flips the bit indicated by pos_error,  |
// |            classifies the word and extracts the data nibble through a    |
// |            2-stage valid/ready pipeline.                                 |
// | Ports    : clk, rst                 clock, synchronous active-high reset |
// |            in_valid/in_ready        input handshake                      |
// |            palabra_rx[7:0]          received codeword, [0] = p0          |
// |            pos_error[3:0]           [2:0] syndrome, [3] parity mismatch  |
// |            out_valid/out_ready      output handshake                     |
// |            palabra_corr[7:0]        corrected word                       |
// |            dato[3:0]                {w3,w2,w1,w0}                        |
// |            estado[1:0]              estado_t classification              |
// |            cnt_corregidos/cnt_dobles  saturating event counters          |
// |            clr_cont                 synchronous counter clear            |
// | Config   : CORRECTOR_CONTADORES_EN  builds the counters; otherwise the   |
// |            counter outputs are 0 and clr_cont is ignored.                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module corrector_hamming
  import hamming_pkg::*;
#(
  parameter int CONT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        palabra_rx,
  input  logic [3:0]        pos_error,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        palabra_corr,
  output logic [3:0]        dato,
  output logic [1:0]        estado,
  output logic [CONT_W-1:0] cnt_corregidos,
  output logic [CONT_W-1:0] cnt_dobles,
  input  logic              clr_cont
);

  // Stage 1: raw word, one-hot flip mask, class
  logic       v1_q,    v1_d;
  logic [7:0] pal1_q,  pal1_d;
  logic [7:0] mask1_q, mask1_d;
  estado_t    est1_q,  est1_d;

  // Stage 2: corrected word, nibble, class
  logic       v2_q,    v2_d;
  logic [7:0] corr2_q, corr2_d;
  logic [3:0] dato2_q, dato2_d;
  estado_t    est2_q,  est2_d;

  logic       en1;
  logic       en2;
  logic [7:0] mask_in;
  estado_t    est_in;
  logic [7:0] pal1_corr;

  assign en2      = !v2_q || out_ready;
  assign en1      = !v1_q || en2;
  assign in_ready = en1;

  // Classification. A parity mismatch means an odd number of flips, so a
  // single error: syndrome 0 points at p0, otherwise at the syndrome position.
  // A syndrome with matching overall parity is an even (double) error and is
  // left untouched.
  always_comb begin
    mask_in = '0;
    est_in  = SIN_ERROR;
    if (pos_error[3]) begin
      est_in = CORREGIDO;
      if (pos_error[2:0] == 3'd0) begin
        mask_in[POS_P0] = 1'b1;
      end else begin
        mask_in[pos_error[2:0]] = 1'b1;
      end
    end else if (pos_error[2:0] != 3'd0) begin
      est_in = DOBLE;
    end
  end

  assign pal1_corr = pal1_q ^ mask1_q;

  always_comb begin
    v1_d    = v1_q;
    pal1_d  = pal1_q;
    mask1_d = mask1_q;
    est1_d  = est1_q;
    if (en1) begin
      v1_d = in_valid;
      if (in_valid) begin
        pal1_d  = palabra_rx;
        mask1_d = mask_in;
        est1_d  = est_in;
      end
    end
  end

  // Stage 2 only loads on a real transfer, so the outputs stay frozen
  // while out_valid is held against a low out_ready.
  always_comb begin
    v2_d    = v2_q;
    corr2_d = corr2_q;
    dato2_d = dato2_q;
    est2_d  = est2_q;
    if (en2) begin
      v2_d = v1_q;
      if (v1_q) begin
        corr2_d = pal1_corr;
        dato2_d = extraer_dato(pal1_corr);
        est2_d  = est1_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      pal1_q  <= '0;
      mask1_q <= '0;
      est1_q  <= SIN_ERROR;
      v2_q    <= 1'b0;
      corr2_q <= '0;
      dato2_q <= '0;
      est2_q  <= SIN_ERROR;
    end else begin
      v1_q    <= v1_d;
      pal1_q  <= pal1_d;
      mask1_q <= mask1_d;
      est1_q  <= est1_d;
      v2_q    <= v2_d;
      corr2_q <= corr2_d;
      dato2_q <= dato2_d;
      est2_q  <= est2_d;
    end
  end

  assign out_valid    = v2_q;
  assign palabra_corr = corr2_q;
  assign dato         = dato2_q;
  assign estado       = est2_q;

`ifdef CORRECTOR_CONTADORES_EN
  logic out_fire;
  logic inc_corr;
  logic inc_doble;

  assign out_fire  = v2_q && out_ready;
  assign inc_corr  = out_fire && (est2_q == CORREGIDO);
  assign inc_doble = out_fire && (est2_q == DOBLE);

  contador_sat #(.W(CONT_W)) u_cnt_corregidos (
    .clk (clk),
    .rst (rst),
    .clr (clr_cont),
    .inc (inc_corr),
    .q   (cnt_corregidos)
  );

  contador_sat #(.W(CONT_W)) u_cnt_dobles (
    .clk (clk),
    .rst (rst),
    .clr (clr_cont),
    .inc (inc_doble),
    .q   (cnt_dobles)
  );
`else
  logic unused_clr_cont;

  assign unused_clr_cont = clr_cont;
  assign cnt_corregidos  = '0;
  assign cnt_dobles      = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_corrector_hamming.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_corrector_hamming                                          |
// | Purpose  : Self-checking bench for corrector_hamming. Directed cases for |
// |            the documented words, backpressure, saturation, clear and    |
// |            mid-stream reset, then a randomized phase against a           |
// |            behavioural model (expected-word queue + occupancy rules).    |
// | Config   : honours CORRECTOR_CONTADORES_EN for the counter expectations. |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_corrector_hamming;

  localparam int CONT_W = 4;
  localparam int CMAX   = (1 << CONT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        palabra_rx;
  logic [3:0]        pos_error;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        palabra_corr;
  logic [3:0]        dato;
  logic [1:0]        estado;
  logic [CONT_W-1:0] cnt_corregidos;
  logic [CONT_W-1:0] cnt_dobles;
  logic              clr_cont;

  corrector_hamming #(.CONT_W(CONT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .palabra_rx     (palabra_rx),
    .pos_error      (pos_error),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .palabra_corr   (palabra_corr),
    .dato           (dato),
    .estado         (estado),
    .cnt_corregidos (cnt_corregidos),
    .cnt_dobles     (cnt_dobles),
    .clr_cont       (clr_cont)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] corr;
    logic [3:0] dato;
    logic [1:0] est;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   m_corr = 0;
  int   m_dob  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: parity mismatch = single error (syndrome 0 -> p0), syndrome
  // without mismatch = double error, untouched.
  function automatic exp_t modelo(input logic [7:0] rx, input logic [3:0] pe);
    exp_t e;
    int   syn;
    syn    = int'(pe[2:0]);
    e.corr = rx;
    e.est  = 2'd0;
    e.cyc  = 0;
    if (pe[3]) begin
      e.est       = 2'd1;
      e.corr[syn] = ~rx[syn];
    end else if (syn != 0) begin
      e.est = 2'd2;
    end
    e.dato = {e.corr[7], e.corr[6], e.corr[5], e.corr[3]};
    return e;
  endfunction

  // One clock cycle: check counters and handshake at the negedge, score any
  // transfer, then let the rising edge happen.
  task automatic ciclo(input logic iv, input logic [7:0] rx, input logic [3:0] pe,
                       input logic ordy, input logic clr, output logic acc);
    exp_t e;
    logic exp_ov;
    logic exp_ir;
    @(negedge clk);
    chk("cnt_corregidos", 32'(cnt_corregidos), 32'(m_corr));
    chk("cnt_dobles", 32'(cnt_dobles), 32'(m_dob));
    in_valid   = iv;
    palabra_rx = rx;
    pos_error  = pe;
    out_ready  = ordy;
    clr_cont   = clr;
    #1;
    exp_ov = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
    exp_ir = !((q.size() == 2) && !ordy);
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("in_ready", 32'(in_ready), 32'(exp_ir));
    acc = iv && in_ready;
    if (out_valid && ordy) begin
      if (q.size() == 0) begin
        chk("unexpected_word", 32'(palabra_corr), 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("palabra_corr", 32'(palabra_corr), 32'(e.corr));
        chk("dato", 32'(dato), 32'(e.dato));
        chk("estado", 32'(estado), 32'(e.est));
`ifdef CORRECTOR_CONTADORES_EN
        if (!clr) begin
          if (e.est == 2'd1 && m_corr < CMAX) m_corr++;
          if (e.est == 2'd2 && m_dob < CMAX) m_dob++;
        end
`endif
      end
    end
`ifdef CORRECTOR_CONTADORES_EN
    if (clr) begin
      m_corr = 0;
      m_dob  = 0;
    end
`endif
    if (acc) begin
      e     = modelo(rx, pe);
      e.cyc = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic drenar();
    logic a;
    for (int i = 0; i < 10 && q.size() > 0; i++) ciclo(1'b0, 8'h00, 4'h0, 1'b1, 1'b0, a);
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  // Documented word: hold it at the output for one stalled cycle and compare
  // against literal values, then release it through the scoreboard.
  task automatic directo(input string tag, input logic [7:0] rx, input logic [3:0] pe,
                         input logic [7:0] corr, input logic [3:0] d, input logic [1:0] est);
    logic a;
    ciclo(1'b1, rx, pe, 1'b0, 1'b0, a);
    ciclo(1'b0, 8'h00, 4'h0, 1'b0, 1'b0, a);
    #1;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_corr"}, 32'(palabra_corr), 32'(corr));
    chk({tag, "_dato"}, 32'(dato), 32'(d));
    chk({tag, "_estado"}, 32'(estado), 32'(est));
    ciclo(1'b0, 8'h00, 4'h0, 1'b1, 1'b0, a);
  endtask

  initial begin
    logic       a;
    int         n_acc;
    int         idx;
    logic       p_iv;
    logic [7:0] p_rx;
    logic [3:0] p_pe;
    logic [7:0] bp_w [4];

    rst        = 1'b1;
    in_valid   = 1'b0;
    palabra_rx = 8'h00;
    pos_error  = 4'h0;
    out_ready  = 1'b0;
    clr_cont   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_palabra", 32'(palabra_corr), 32'd0);
    chk("rst_estado", 32'(estado), 32'd0);
    @(posedge clk);

    directo("clean", 8'hAA, 4'h0, 8'hAA, 4'hB, 2'd0);
    directo("err_w1", 8'h8A, 4'hD, 8'hAA, 4'hB, 2'd1);
    directo("err_p0", 8'hAB, 4'h8, 8'hAA, 4'hB, 2'd1);
    directo("doble", 8'h8E, 4'h6, 8'h8E, 4'h9, 2'd2);
    drenar();

    // Backpressure: 4 words offered, out_ready low for 5 cycles
    bp_w[0] = 8'h12; bp_w[1] = 8'h34; bp_w[2] = 8'h56; bp_w[3] = 8'h78;
    n_acc = 0;
    idx   = 0;
    for (int t = 0; t < 12 && idx < 4; t++) begin
      ciclo(1'b1, bp_w[idx], 4'h9, (t >= 5), 1'b0, a);
      if (a) begin
        idx++;
        n_acc++;
      end
      if (t == 4) chk("bp_accepts_stalled", 32'(n_acc), 32'd2);
    end
    chk("bp_all_accepted", 32'(idx), 32'd4);
    drenar();

    // Saturation of both counters
    for (int i = 0; i < CMAX + 4; i++) ciclo(1'b1, 8'($urandom), 4'h8 | 4'($urandom_range(0, 7)), 1'b1, 1'b0, a);
    for (int i = 0; i < CMAX + 4; i++) ciclo(1'b1, 8'($urandom), 4'($urandom_range(1, 7)), 1'b1, 1'b0, a);
    drenar();
    ciclo(1'b0, 8'h00, 4'h0, 1'b1, 1'b0, a);

    // Clear coincident with a CORREGIDO transfer
    ciclo(1'b1, 8'h8A, 4'hD, 1'b0, 1'b0, a);
    ciclo(1'b0, 8'h00, 4'h0, 1'b0, 1'b0, a);
    ciclo(1'b0, 8'h00, 4'h0, 1'b1, 1'b1, a);
    ciclo(1'b0, 8'h00, 4'h0, 1'b1, 1'b0, a);

    // Randomized traffic; upstream holds a refused word
    p_iv = 1'b0;
    p_rx = 8'h00;
    p_pe = 4'h0;
    for (int i = 0; i < 400; i++) begin
      if (!p_iv) begin
        p_iv = ($urandom_range(0, 3) != 0);
        p_rx = 8'($urandom);
        p_pe = 4'($urandom);
      end
      ciclo(p_iv, p_rx, p_pe, ($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0), a);
      if (a) p_iv = 1'b0;
    end

    // Reset with both stages full
    for (int i = 0; i < 4; i++) ciclo(1'b1, 8'($urandom), 4'($urandom), 1'b0, 1'b0, a);
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_palabra", 32'(palabra_corr), 32'd0);
    chk("mrst_dato", 32'(dato), 32'd0);
    chk("mrst_estado", 32'(estado), 32'd0);
    chk("mrst_cnt_corr", 32'(cnt_corregidos), 32'd0);
    chk("mrst_cnt_dob", 32'(cnt_dobles), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    m_corr = 0;
    m_dob  = 0;
    @(posedge clk);
    cyc++;
    directo("post_rst", 8'h8A, 4'hD, 8'hAA, 4'hB, 2'd1);
    drenar();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
